// File: rtl/calc_entry_ctrl.sv
// Calculator operand-entry controller: builds BCD operands from keypad strobes,
// issues a valid/ready request to the arithmetic unit and shows the result.
module calc_entry_ctrl #(
   parameter int DIGITS = 4,
   parameter int OP_W   = 2,
   localparam int W     = 4 * DIGITS
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [3:0]      num_val_i,
   input  logic [OP_W-1:0] op_val_i,
   input  logic            is_num_i,
   input  logic            is_op_i,
   input  logic            is_eq_i,
   output logic            req_valid_o,
   input  logic            req_ready_i,
   output logic [W-1:0]    req_a_o,
   output logic [W-1:0]    req_b_o,
   output logic [OP_W-1:0] req_op_o,
   input  logic            res_valid_i,
   input  logic [W-1:0]    res_bcd_i,
   output logic            busy_o,
   output logic [W-1:0]    data_out_bcd_o
);

   // state    | meaning
   // ENTER_A  | editing operand A
   // ENTER_B  | operator latched, editing operand B
   // REQ      | request presented, waiting for req_ready
   // WAIT_RES | request accepted, waiting for res_valid
   // SHOW_RES | result displayed, result is the new A
   typedef enum logic [2:0] {ENTER_A, ENTER_B, REQ, WAIT_RES, SHOW_RES} state_t;

   localparam int CW = $clog2(DIGITS + 1);

   state_t          state_q;
   logic [W-1:0]    a_q, b_q, disp_q;
   logic [OP_W-1:0] op_q;
   logic [CW-1:0]   cnt_q;
   logic            req_valid_q, busy_q;

   logic            digit_bcd, digit_take;
   logic [W-1:0]    opnd, shifted, fresh;
   logic [CW-1:0]   fresh_cnt;

   // A leading zero into an empty operand is accepted but changes nothing.
   always_comb begin
      digit_bcd  = (num_val_i <= 4'd9);
      digit_take = digit_bcd && (cnt_q != CW'(DIGITS)) &&
                   !((cnt_q == '0) && (num_val_i == 4'd0));
      opnd       = (state_q == ENTER_B) ? b_q : a_q;
      shifted    = {opnd[W-5:0], num_val_i};
      fresh      = digit_bcd ? W'(num_val_i) : '0;
      fresh_cnt  = (digit_bcd && (num_val_i != 4'd0)) ? CW'(1) : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ENTER_A;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         cnt_q       <= '0;
         disp_q      <= '0;
         req_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ENTER_A: begin
               if (is_num_i) begin
                  if (digit_take) begin
                     a_q    <= shifted;
                     cnt_q  <= cnt_q + CW'(1);
                     disp_q <= shifted;
                  end
               end else if (is_op_i) begin
                  op_q    <= op_val_i;
                  b_q     <= '0;
                  cnt_q   <= '0;
                  disp_q  <= '0;
                  state_q <= ENTER_B;
               end
            end
            ENTER_B: begin
               if (is_num_i) begin
                  if (digit_take) begin
                     b_q    <= shifted;
                     cnt_q  <= cnt_q + CW'(1);
                     disp_q <= shifted;
                  end
               end else if (is_op_i) begin
                  op_q <= op_val_i;
               end else if (is_eq_i) begin
                  req_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= REQ;
               end
            end
            REQ: begin
               if (req_valid_q && req_ready_i) begin
                  req_valid_q <= 1'b0;
                  state_q     <= WAIT_RES;
               end
            end
            WAIT_RES: begin
               if (res_valid_i) begin
                  a_q     <= res_bcd_i;
                  disp_q  <= res_bcd_i;
                  busy_q  <= 1'b0;
                  state_q <= SHOW_RES;
               end
            end
            SHOW_RES: begin
               if (is_num_i) begin
                  a_q     <= fresh;
                  cnt_q   <= fresh_cnt;
                  disp_q  <= fresh;
                  state_q <= ENTER_A;
               end else if (is_op_i) begin
                  op_q    <= op_val_i;
                  b_q     <= '0;
                  cnt_q   <= '0;
                  disp_q  <= '0;
                  state_q <= ENTER_B;
               end else if (is_eq_i) begin
                  req_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= REQ;
               end
            end
            default: state_q <= ENTER_A;
         endcase
      end
   end

   assign req_valid_o    = req_valid_q;
   assign req_a_o        = a_q;
   assign req_b_o        = b_q;
   assign req_op_o       = op_q;
   assign busy_o         = busy_q;
   assign data_out_bcd_o = disp_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: decimal-arithmetic reference model compared every
// cycle, plus literal checks at key points of the directed scenarios.
module tb_calc_entry_ctrl;
   localparam int DIGITS = 4;
   localparam int OP_W   = 2;
   localparam int W      = 4 * DIGITS;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [3:0]      num_val = '0;
   logic [OP_W-1:0] op_val = '0;
   logic            is_num = 1'b0, is_op = 1'b0, is_eq = 1'b0;
   logic            req_ready = 1'b0, res_valid = 1'b0;
   logic [W-1:0]    res_bcd = '0;
   logic            req_valid, busy;
   logic [W-1:0]    req_a, req_b, data_out;
   logic [OP_W-1:0] req_op;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   calc_entry_ctrl #(.DIGITS(DIGITS), .OP_W(OP_W)) dut (
      .clk_i(clk), .rst_i(rst), .num_val_i(num_val), .op_val_i(op_val),
      .is_num_i(is_num), .is_op_i(is_op), .is_eq_i(is_eq),
      .req_valid_o(req_valid), .req_ready_i(req_ready),
      .req_a_o(req_a), .req_b_o(req_b), .req_op_o(req_op),
      .res_valid_i(res_valid), .res_bcd_i(res_bcd),
      .busy_o(busy), .data_out_bcd_o(data_out)
   );

   always #5 clk = ~clk;

   // Model: operands kept as plain decimal integers plus a digit count.
   localparam int M_A = 0, M_B = 1, M_REQ = 2, M_WAIT = 3, M_SHOW = 4;
   int m_mode = M_A, m_a = 0, m_b = 0, m_op = 0, m_cnt = 0, m_disp = 0;

   function automatic int to_bcd(input int v);
      int r = 0;
      for (int i = 0; i < DIGITS; i++) begin
         r += (v % 10) << (4 * i);
         v /= 10;
      end
      return r;
   endfunction

   function automatic int from_bcd(input int b);
      int r = 0;
      for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + ((b >> (4 * i)) & 15);
      return r;
   endfunction

   task automatic push(input int v, input int c, input int d, output int vo, output int co);
      vo = v;
      co = c;
      if (d <= 9 && c < DIGITS && !(c == 0 && d == 0)) begin
         vo = v * 10 + d;
         co = c + 1;
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_mode = M_A; m_a = 0; m_b = 0; m_op = 0; m_cnt = 0; m_disp = 0;
      end else begin
         case (m_mode)
            M_A:
               if (is_num) begin push(m_a, m_cnt, int'(num_val), m_a, m_cnt); m_disp = m_a; end
               else if (is_op) begin m_op = int'(op_val); m_b = 0; m_cnt = 0; m_disp = 0; m_mode = M_B; end
            M_B:
               if (is_num) begin push(m_b, m_cnt, int'(num_val), m_b, m_cnt); m_disp = m_b; end
               else if (is_op) m_op = int'(op_val);
               else if (is_eq) m_mode = M_REQ;
            M_REQ:
               if (req_ready) m_mode = M_WAIT;
            M_WAIT:
               if (res_valid) begin m_a = from_bcd(int'(res_bcd)); m_disp = m_a; m_mode = M_SHOW; end
            M_SHOW:
               if (is_num) begin
                  m_cnt = 0;
                  push(0, 0, int'(num_val), m_a, m_cnt);
                  m_disp = m_a; m_mode = M_A;
               end else if (is_op) begin m_op = int'(op_val); m_b = 0; m_cnt = 0; m_disp = 0; m_mode = M_B; end
               else if (is_eq) m_mode = M_REQ;
            default: m_mode = M_A;
         endcase
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_valid", int'(req_valid), int'(m_mode == M_REQ));
         chk("busy", int'(busy), int'(m_mode == M_REQ || m_mode == M_WAIT));
         chk("req_a", int'(req_a), to_bcd(m_a));
         chk("req_b", int'(req_b), to_bcd(m_b));
         chk("req_op", int'(req_op), m_op);
         chk("display", int'(data_out), to_bcd(m_disp));
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic digit(input logic [3:0] d);
      num_val = d; is_num = 1'b1; tick(1); is_num = 1'b0;
   endtask

   task automatic oper(input logic [OP_W-1:0] o);
      op_val = o; is_op = 1'b1; tick(1); is_op = 1'b0;
   endtask

   task automatic equals();
      is_eq = 1'b1; tick(1); is_eq = 1'b0;
   endtask

   task automatic handshake(input logic [W-1:0] r);
      req_ready = 1'b1; tick(1); req_ready = 1'b0;
      chk("lit_valid_drop", int'(req_valid), 0);
      tick(1);
      res_bcd = r; res_valid = 1'b1; tick(1); res_valid = 1'b0;
   endtask

   initial begin
      tick(2);
      rst = 1'b0;
      chk_en = 1'b1;
      chk("lit_reset_disp", int'(data_out), 0);
      chk("lit_reset_valid", int'(req_valid), 0);

      // Digit entry and saturation at DIGITS
      digit(4'd1); digit(4'd2); digit(4'd3);
      chk("lit_0123", int'(data_out), 'h0123);
      digit(4'd4);
      chk("lit_1234", int'(data_out), 'h1234);
      digit(4'd5); digit(4'd6); digit(4'd7); digit(4'd8);
      chk("lit_1234_hold", int'(data_out), 'h1234);

      // Leading zeros
      rst = 1'b1; tick(1); rst = 1'b0;
      digit(4'd0); digit(4'd0);
      chk("lit_lead_zero", int'(data_out), 0);
      digit(4'd7);
      chk("lit_lead_7", int'(data_out), 'h0007);

      // 12 op1 7 =, ready held low
      rst = 1'b1; tick(1); rst = 1'b0;
      digit(4'd1); digit(4'd2); oper(2'd1);
      chk("lit_enter_b_disp", int'(data_out), 0);
      digit(4'd7); equals();
      chk("lit_req_valid", int'(req_valid), 1);
      chk("lit_req_a", int'(req_a), 'h0012);
      chk("lit_req_b", int'(req_b), 'h0007);
      chk("lit_req_op", int'(req_op), 1);
      is_num = 1'b1; num_val = 4'd3; tick(5); is_num = 1'b0;
      chk("lit_req_stable_a", int'(req_a), 'h0012);
      chk("lit_req_stable_b", int'(req_b), 'h0007);
      handshake(16'h0019);
      chk("lit_res_disp", int'(data_out), 'h0019);
      chk("lit_res_busy", int'(busy), 0);

      // Chaining: result becomes A
      oper(2'd2); digit(4'd1); equals();
      chk("lit_chain_a", int'(req_a), 'h0019);
      chk("lit_chain_b", int'(req_b), 'h0001);
      handshake(16'h0020);
      // Re-issue from SHOW_RES
      equals();
      chk("lit_reissue_a", int'(req_a), 'h0020);
      chk("lit_reissue_op", int'(req_op), 2);
      handshake(16'h0021);
      digit(4'd5);
      chk("lit_new_entry", int'(data_out), 'h0005);

      // num & op together with invalid digit; eq and stray res_valid in ENTER_A
      num_val = 4'hA; op_val = 2'd3; is_num = 1'b1; is_op = 1'b1; tick(1);
      is_num = 1'b0; is_op = 1'b0;
      chk("lit_drop_both", int'(data_out), 'h0005);
      equals();
      chk("lit_eq_in_a", int'(req_valid), 0);
      res_bcd = 16'h0999; res_valid = 1'b1; tick(1); res_valid = 1'b0;
      digit(4'd3);
      chk("lit_still_a", int'(data_out), 'h0053);

      // Reset while in REQ
      oper(2'd3); digit(4'd4); equals();
      chk("lit_pre_rst_valid", int'(req_valid), 1);
      rst = 1'b1; tick(1); rst = 1'b0;
      chk("lit_rst_valid", int'(req_valid), 0);
      chk("lit_rst_busy", int'(busy), 0);
      chk("lit_rst_disp", int'(data_out), 0);
      digit(4'd9);
      chk("lit_after_rst", int'(data_out), 'h0009);
      tick(2);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
